// File: rtl/core_pkg.sv
// Core-wide lane/VFU geometry and instruction ID type.
package core_pkg;

  localparam int unsigned NrLane          = 4;
  localparam int unsigned NrLaneVFU       = 3;
  localparam int unsigned InsnIdW         = 4;
  localparam int unsigned DoneGatherDepth = 4;

  typedef logic [InsnIdW-1:0] insn_id_t;

endpackage

// File: rtl/done_gather_vfu.sv
// One VFU's completion gather: per-lane counters, ID FIFO, lead detection and ID check.
// Emits done one cycle after all lanes hold a completion; no backpressure, err_o flags overflow/mismatch.
module done_gather_vfu
  import core_pkg::*;
#(
  parameter int unsigned NrLane = core_pkg::NrLane,
  parameter int unsigned Depth  = DoneGatherDepth
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrLane-1:0]               lane_done_i,
  input  logic [NrLane-1:0][InsnIdW-1:0]  lane_done_id_i,
  output logic                            done_o,
  output logic [InsnIdW-1:0]              done_id_o,
  output logic                            err_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [CntW-1:0] cnt_q [NrLane];
  logic [CntW-1:0] cnt_d [NrLane];
  insn_id_t        mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] occ_q;

  logic            emit;
  logic            push;
  insn_id_t        push_id;
  logic [CntW-1:0] lead;
  logic            ovf_any;
  logic            mism_any;
  logic            lane_ovf;
  logic [PtrW-1:0] chk_idx;

  always_comb begin
    lead     = '0;
    emit     = 1'b1;
    push     = 1'b0;
    push_id  = '0;
    ovf_any  = 1'b0;
    mism_any = 1'b0;
    lane_ovf = 1'b0;
    chk_idx  = '0;
    for (int l = 0; l < NrLane; l++) begin
      if (cnt_q[l] > lead) lead = cnt_q[l];
      if (cnt_q[l] == '0) emit = 1'b0;
    end
    for (int l = 0; l < NrLane; l++) begin
      lane_ovf = lane_done_i[l] && (cnt_q[l] == CntW'(Depth)) && !emit;
      chk_idx  = rd_q + cnt_q[l][PtrW-1:0];
      if (lane_ovf) begin
        ovf_any = 1'b1;
      end else if (lane_done_i[l] && (cnt_q[l] == lead)) begin
        // Only the lowest-index leading lane supplies the new ID.
        if (!push && ((occ_q != CntW'(Depth)) || emit)) begin
          push    = 1'b1;
          push_id = lane_done_id_i[l];
        end
      end else if (lane_done_i[l] && (lane_done_id_i[l] != mem_q[chk_idx])) begin
        mism_any = 1'b1;
      end
      cnt_d[l] = cnt_q[l];
      if (lane_done_i[l] && !lane_ovf && !emit) cnt_d[l] = cnt_q[l] + 1'b1;
      else if (!(lane_done_i[l] && !lane_ovf) && emit) cnt_d[l] = cnt_q[l] - 1'b1;
    end
    err_o = ovf_any | mism_any;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int l = 0; l < NrLane; l++) cnt_q[l] <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      occ_q     <= '0;
      done_o    <= 1'b0;
      done_id_o <= '0;
    end else begin
      for (int l = 0; l < NrLane; l++) cnt_q[l] <= cnt_d[l];
      if (push) wr_q <= wr_q + 1'b1;
      if (emit) rd_q <= rd_q + 1'b1;
      if (push && !emit) occ_q <= occ_q + 1'b1;
      else if (!push && emit) occ_q <= occ_q - 1'b1;
      done_o <= emit;
      if (emit) done_id_o <= mem_q[rd_q];
    end
  end

  // Storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_id;
  end

endmodule

// File: rtl/lane_done_gather.sv
// Aligns per-lane VFU completions into one done pulse per instruction; last lane pulse at t -> done at t+2.
// No backpressure; err_o is sticky until reset.
module lane_done_gather
  import core_pkg::*;
#(
  parameter int unsigned NrLane    = core_pkg::NrLane,
  parameter int unsigned NrLaneVFU = core_pkg::NrLaneVFU,
  parameter int unsigned Depth     = DoneGatherDepth
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NrLane-1:0][NrLaneVFU-1:0]              lane_done_i,
  input  logic [NrLane-1:0][NrLaneVFU-1:0][InsnIdW-1:0] lane_done_id_i,
  output logic [NrLaneVFU-1:0]                          vfus_done_o,
  output logic [NrLaneVFU-1:0][InsnIdW-1:0]             vfus_done_id_o,
  output logic                                          err_o
);

  logic [NrLaneVFU-1:0] vfu_err;

  for (genvar v = 0; v < NrLaneVFU; v++) begin : g_vfu
    logic [NrLane-1:0]              done_v;
    logic [NrLane-1:0][InsnIdW-1:0] id_v;

    always_comb begin
      for (int l = 0; l < NrLane; l++) begin
        done_v[l] = lane_done_i[l][v];
        id_v[l]   = lane_done_id_i[l][v];
      end
    end

    done_gather_vfu #(
      .NrLane (NrLane),
      .Depth  (Depth)
    ) u_vfu (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .lane_done_i    (done_v),
      .lane_done_id_i (id_v),
      .done_o         (vfus_done_o[v]),
      .done_id_o      (vfus_done_id_o[v]),
      .err_o          (vfu_err[v])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_o <= 1'b0;
    else         err_o <= err_o | (|vfu_err);
  end

endmodule

// File: doc/lane_done_gather.md
Name: lane_done_gather

Overview:
- Collects per-lane, per-VFU completion pulses and emits one aligned done pulse per VFU instruction.
- Fires only once every lane has reported that instruction.
- Sits between the lane array and the instruction launcher, replacing the lane-0-only done forwarding.
- Lanes may finish the same instruction in different cycles; instruction order within one VFU is identical across lanes.

Parameters:
- NrLane, core_pkg::NrLane: number of lanes.
- NrLaneVFU, core_pkg::NrLaneVFU: number of VFUs per lane.
- Depth, 4: maximum outstanding completions one lane may lead the slowest lane by, per VFU. Must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- lane_done_i  in  NrLane x NrLaneVFU  one-cycle done pulse per lane per VFU.
- lane_done_id_i  in  NrLane x NrLaneVFU x insn_id_t  ID qualifying lane_done_i.
- vfus_done_o  out  NrLaneVFU  one-cycle aligned done pulse per VFU.
- vfus_done_id_o  out  NrLaneVFU x insn_id_t  ID of the completed instruction, valid with vfus_done_o.
- err_o  out  1  sticky error: overflow or ID mismatch.

Behaviour:
- Reset: all counters 0, all ID FIFOs empty, vfus_done_o = 0, vfus_done_id_o = 0, err_o = 0.
  - Reset mid-operation discards all pending completions.
  - No done pulse is emitted in the cycle after reset is released.
- Each VFU v is processed independently and identically.
- State per VFU:
  - cnt[l][v], 0..Depth: completions reported by lane l but not yet emitted.
  - idq[v]: ID FIFO, Depth entries, with rd/wr pointers and an occupancy count.
- Lead detection, evaluated each cycle:
  - lead = max over l of cnt[l][v], taken before update.
  - A pulse from lane l with cnt[l][v] == lead is a leading report.
  - If any leading report exists, push lane_done_id_i of the lowest-index leading lane into idq[v].
  - At most one push per cycle per VFU.
- Emit condition: all(cnt[l][v] >= 1), evaluated on current state.
- When the emit condition holds, in the same edge:
  - every cnt[l][v] decrements by 1;
  - idq[v] pops;
  - vfus_done_o[v] is set to 1 next cycle, with vfus_done_id_o[v] = popped head.
- vfus_done_o is registered and otherwise 0. vfus_done_id_o holds its last value when done is 0.
- Latency: the last lane's pulse arriving in cycle t gives vfus_done_o[v] in cycle t+2.
  - Counter update happens at edge t.
  - Emit registration happens at edge t+1.
- Simultaneous events:
  - An incoming pulse and an emit decrement on the same lane net to an unchanged cnt.
  - Push and pop on idq in the same cycle are both performed; the FIFO never reads its own write in that cycle.
  - All lanes pulsing in the same cycle: one push, then emit on the following edge.
- ID check: a non-leading report from lane l with cnt[l][v] = k must carry the ID at idq[v] position rd+k (mod Depth). On mismatch, set err_o.
- Overflow: a pulse arriving when cnt[l][v] == Depth and no emit is pending that cycle sets err_o.
  - In that case cnt saturates and nothing is pushed.
  - An overflowing leading report does not push.
- err_o is cleared only by reset.
- Counter width: $clog2(Depth+1). FIFO pointers: $clog2(Depth) and wrap modulo Depth.

Decomposition:
- core_pkg: insn_id_t, NrLane, NrLaneVFU. Add DoneGatherDepth = 4 as the default for Depth.
- One sub-module, done_gather_vfu: the per-VFU counters, ID FIFO, lead detection, check and emit logic.
  - Instantiated NrLaneVFU times in a generate loop.
  - Top level ORs the per-VFU error bits into the sticky err_o register.

Test Plan:
- Aligned completion (NrLane=4): all lanes pulse VFU0 with ID 3 in cycle 10 -> vfus_done_o[0]=1, vfus_done_id_o[0]=3 in cycle 12 only; err_o=0.
- Skewed completion: lane0 pulses ID 5 at cycle 10, lane1 at 11, lane2 at 13, lane3 at 15 -> exactly one done with ID 5 at cycle 17.
- Lane lead: lane0 reports IDs 1, 2, 3 on VFU1 at cycles 10-12; other lanes report 1, 2, 3 at cycles 20-22 -> done IDs 1, 2, 3 at cycles 22, 23, 24.
- Simultaneous pulse and emit: lane0 pulses ID 8 in the same cycle the emit for ID 7 fires -> cnt[0] stays 1; ID 8 is emitted once the remaining lanes report.
- Overflow: lane0 sends Depth+1=5 pulses while the other lanes stay silent -> err_o=1 from the cycle after the 5th pulse, and no done pulse.
- ID mismatch plus reset: lane0 reports ID 4 and lane1 reports ID 6 for the same slot -> err_o=1. Then hold rst_ni=0 for one cycle -> err_o=0, counters cleared, and no done pulse in the next cycle.
